// File: rtl/fifo_pkg.sv
// Helpers shared by the core's queues: count-field sizing and default geometry.
package fifo_pkg;

  localparam int DEF_DEPTH_LOG2 = 3;

  // Bits needed to hold a value in 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [DEF_DEPTH_LOG2:0] occ_def_t;

endpackage

// File: rtl/fifo_mp_mem.sv
// Register-array storage: PUSH_W writes at consecutive slots from wr_ptr,
// POP_W combinational reads at consecutive slots from rd_ptr.
module fifo_mp_mem #(
  parameter int DEPTH_LOG2 = 3,
  parameter int W          = 40,
  parameter int PUSH_W     = 2,
  parameter int POP_W      = 2
) (
  input  logic                             clk,
  input  logic [PUSH_W-1:0]                we,
  input  logic [DEPTH_LOG2-1:0]            wr_ptr,
  input  logic [PUSH_W-1:0][W-1:0]         wdata,
  input  logic [DEPTH_LOG2-1:0]            rd_ptr,
  output logic [POP_W-1:0][W-1:0]          rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  // Lane addresses never collide because PUSH_W <= DEPTH.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < PUSH_W; i++)
      if (we[i]) mem_d[wr_ptr + ptr_t'(i)] = wdata[i];
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  for (genvar j = 0; j < POP_W; j++) begin : g_rd
    assign rdata[j] = mem_q[rd_ptr + ptr_t'(j)];
  end

endmodule

// File: rtl/fifo_multi_port.sv
// Multi-lane two-field FIFO: all-or-nothing push/pop, show-ahead read lanes,
// occupancy flags, flush and sticky overflow/underflow.
module fifo_multi_port
  import fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int DATA0W     = 32,
  parameter int DATA1W     = 8,
  parameter int PUSH_W     = 2,
  parameter int POP_W      = 2,
  parameter int AFULL_THR  = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            i_flush,
  input  logic [cnt_w(PUSH_W)-1:0]        i_push_cnt,
  input  logic [PUSH_W-1:0][DATA0W-1:0]   i_data0,
  input  logic [PUSH_W-1:0][DATA1W-1:0]   i_data1,
  input  logic [cnt_w(POP_W)-1:0]         i_pop_cnt,
  output logic [POP_W-1:0][DATA0W-1:0]    o_data0,
  output logic [POP_W-1:0][DATA1W-1:0]    o_data1,
  output logic [POP_W-1:0]                o_rd_vld,
  output logic [DEPTH_LOG2:0]             o_count,
  output logic [DEPTH_LOG2:0]             o_free,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_afull,
  output logic                            o_ovf,
  output logic                            o_udf
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int W     = DATA0W + DATA1W;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic ovf_q, ovf_d, udf_q, udf_d;

  cnt_t free, push_n, pop_n;
  logic push_ok, pop_ok;
  logic [PUSH_W-1:0]        we;
  logic [PUSH_W-1:0][W-1:0] wdata;
  logic [POP_W-1:0][W-1:0]  rdata;

  // Acceptance looks only at start-of-cycle occupancy; no same-cycle pop credit.
  assign free    = cnt_t'(DEPTH) - count_q;
  assign push_n  = cnt_t'(i_push_cnt);
  assign pop_n   = cnt_t'(i_pop_cnt);
  assign push_ok = push_n <= free;
  assign pop_ok  = pop_n <= count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(push_n);
      else         ovf_d    = 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ptr_t'(pop_n);
      else         udf_d    = 1'b1;
      count_d = count_q + (push_ok ? push_n : '0) - (pop_ok ? pop_n : '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  for (genvar i = 0; i < PUSH_W; i++) begin : g_wr
    assign we[i]    = !i_flush && push_ok && (push_n > cnt_t'(i));
    assign wdata[i] = {i_data0[i], i_data1[i]};
  end

  fifo_mp_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (W),
    .PUSH_W     (PUSH_W),
    .POP_W      (POP_W)
  ) u_mem (
    .clk    (clk),
    .we     (we),
    .wr_ptr (wr_ptr_q),
    .wdata  (wdata),
    .rd_ptr (rd_ptr_q),
    .rdata  (rdata)
  );

  for (genvar j = 0; j < POP_W; j++) begin : g_rd
    assign o_data0[j]  = rdata[j][W-1:DATA1W];
    assign o_data1[j]  = rdata[j][DATA1W-1:0];
    assign o_rd_vld[j] = count_q > cnt_t'(j);
  end

  assign o_count = count_q;
  assign o_free  = free;
  assign o_full  = count_q == cnt_t'(DEPTH);
  assign o_empty = count_q == '0;
  assign o_afull = 32'(free) < AFULL_THR;
  assign o_ovf   = ovf_q;
  assign o_udf   = udf_q;

  a_push_range: assert property (@(posedge clk) disable iff (!rstn) 32'(i_push_cnt) <= PUSH_W);
  a_pop_range:  assert property (@(posedge clk) disable iff (!rstn) 32'(i_pop_cnt) <= POP_W);

endmodule
